// File: rtl/uart_rx_fifo_if.sv
// Receive-side bus of uart_rx_fifo: serial line in, FIFO read port and status out.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                          serial_in;
    logic                          data_read;
    logic [DATA_BITS-1:0]          rx_data;
    logic                          data_ready;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overrun_error;
    logic                          framing_error;
    logic                          parity_error;

    modport slave (
        input  serial_in, data_read,
        output rx_data, data_ready, fifo_count,
               overrun_error, framing_error, parity_error
    );

    modport master (
        output serial_in, data_read,
        input  rx_data, data_ready, fifo_count,
               overrun_error, framing_error, parity_error
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Serial receiver: start/bit timing/shift/stop in one FSM, good frames into a
// first-word-fall-through FIFO, with framing, parity and overrun reporting.
module uart_rx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 10,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           n_rst,
    uart_rx_fifo_if.slave  bus
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int BW   = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_nxt;
    logic                 sync1, sync2, line_prev;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [BW-1:0]        bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 par_bit, par_bit_nxt;
    logic                 clr_err, stop_sample, par_bad, frame_ok;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CNTW-1:0]      count;
    logic                 full, pop, push;
    logic                 ovr_q, frm_q, par_q;

    wire line = sync2;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
        end else begin
            sync1     <= bus.serial_in;
            sync2     <= sync1;
            line_prev <= sync2;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shreg     <= shreg_nxt;
            par_bit   <= par_bit_nxt;
        end
    end

    // cnt counts cycles since the start edge (START) or since the last sample.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CW'(1);
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        par_bit_nxt = par_bit;
        clr_err     = 1'b0;
        stop_sample = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (line_prev && !line) begin
                    cnt_nxt   = CW'(1);
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == CW'(CLKS_PER_BIT / 2)) begin
                    if (line) begin
                        state_nxt = IDLE;
                    end else begin
                        clr_err     = 1'b1;
                        cnt_nxt     = CW'(1);
                        bit_idx_nxt = '0;
                        state_nxt   = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt == CW'(CLKS_PER_BIT)) begin
                    cnt_nxt   = CW'(1);
                    shreg_nxt = {line, shreg[DATA_BITS-1:1]};
                    if (bit_idx == BW'(DATA_BITS - 1))
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                    else
                        bit_idx_nxt = bit_idx + BW'(1);
                end
            end
            PARITY: begin
                if (cnt == CW'(CLKS_PER_BIT)) begin
                    cnt_nxt     = CW'(1);
                    par_bit_nxt = line;
                    state_nxt   = STOP;
                end
            end
            STOP: begin
                if (cnt == CW'(CLKS_PER_BIT)) begin
                    stop_sample = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign par_bad  = (PARITY_EN != 0) && (((^shreg) ^ par_bit) != (PARITY_ODD != 0));
    assign frame_ok = stop_sample && line && !par_bad;
    assign full     = (count == CNTW'(FIFO_DEPTH));
    assign pop      = bus.data_read && (count != '0);
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign push     = frame_ok && (!full || pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovr_q  <= 1'b0;
            frm_q  <= 1'b0;
            par_q  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CNTW'(1);
            else if (pop && !push)
                count <= count - CNTW'(1);

            if (frame_ok && full && !pop)
                ovr_q <= 1'b1;
            else if (pop)
                ovr_q <= 1'b0;

            if (clr_err) begin
                frm_q <= 1'b0;
                par_q <= 1'b0;
            end else if (stop_sample) begin
                if (!line)
                    frm_q <= 1'b1;
                if (par_bad)
                    par_q <= 1'b1;
            end
        end
    end

    assign bus.rx_data       = (count != '0) ? mem[rd_ptr] : '0;
    assign bus.data_ready    = (count != '0);
    assign bus.fifo_count    = count;
    assign bus.overrun_error = ovr_q;
    assign bus.framing_error = frm_q;
    assign bus.parity_error  = par_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed frames on an 8N1 and an 8E1 instance,
// scoreboard queue of expected bytes checked by a pop monitor.
module tb_uart_rx_fifo;
    localparam int CPB = 10;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) b0();
    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) b1();

    uart_rx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(4))
        u_dut (.clk(clk), .n_rst(n_rst), .bus(b0));
    uart_rx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(4))
        u_par (.clk(clk), .n_rst(n_rst), .bus(b1));

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] q0[$];
    bit ov_exp = 1'b0;
    bit fe_exp[2];
    bit pe_exp[2];
    logic rdy_pre, rdy_post;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted pop on the 8N1 instance is checked
    always begin
        @(negedge clk);
        #2;
        if (b0.data_read && b0.data_ready) begin
            n_cmp++;
            if (q0.size() == 0) begin
                n_bad++;
                $display("FAIL pop_unexpected: got %02h expected none", b0.rx_data);
            end else begin
                logic [7:0] e;
                e = q0.pop_front();
                if (b0.rx_data !== e) begin
                    n_bad++;
                    $display("FAIL pop_data: got %02h expected %02h", b0.rx_data, e);
                end
            end
            ov_exp = 1'b0;
        end
    end

    task automatic set_line(input bit sel, input logic v);
        if (sel) b1.serial_in = v;
        else     b0.serial_in = v;
    endtask

    task automatic drive_bit(input bit sel, input logic v);
        set_line(sel, v);
        repeat (CPB) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge where the next frame may start.
    task automatic send(input bit sel, input logic [7:0] d, input bit has_par,
                        input bit par, input bit stop, input bit pop_at_stop);
        bit good;
        drive_bit(sel, 1'b0);
        fe_exp[sel] = 1'b0;
        pe_exp[sel] = 1'b0;
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (has_par) drive_bit(sel, par);
        set_line(sel, stop);
        for (int j = 1; j <= CPB; j++) begin
            @(negedge clk);
            if (j == 7) begin
                rdy_pre = sel ? b1.data_ready : b0.data_ready;
                if (pop_at_stop) b0.data_read = 1'b1;
            end
            if (j == 8) begin
                rdy_post = sel ? b1.data_ready : b0.data_ready;
                b0.data_read = 1'b0;
            end
        end
        set_line(sel, 1'b1);
        if (!stop) fe_exp[sel] = 1'b1;
        if (has_par && ((^d) ^ par)) pe_exp[sel] = 1'b1;
        good = stop && !(has_par && ((^d) ^ par));
        if (good && !sel) begin
            if (q0.size() < 4) q0.push_back(d);
            else ov_exp = 1'b1;
        end
    endtask

    task automatic read_one(input bit sel);
        if (sel) b1.data_read = 1'b1; else b0.data_read = 1'b1;
        @(negedge clk);
        if (sel) b1.data_read = 1'b0; else b0.data_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_flags0(input string tag);
        chk({tag, "_count"},   32'(b0.fifo_count), 32'(q0.size()));
        chk({tag, "_overrun"}, 32'(b0.overrun_error), 32'(ov_exp));
        chk({tag, "_framing"}, 32'(b0.framing_error), 32'(fe_exp[0]));
        chk({tag, "_parity"},  32'(b0.parity_error), 32'(pe_exp[0]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0;
        b0.serial_in = 1'b1; b0.data_read = 1'b0;
        b1.serial_in = 1'b1; b1.data_read = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(b0.data_ready), 0);
        chk("rst_rx_data", 32'(b0.rx_data), 0);
        chk_flags0("rst");
        n_rst = 1'b1;
        repeat (5) @(negedge clk);

        // Single 0xA5 frame, ready appears the cycle after the stop sample
        send(0, 8'hA5, 0, 0, 1, 0);
        chk("a5_ready_before", 32'(rdy_pre), 0);
        chk("a5_ready_after", 32'(rdy_post), 1);
        chk("a5_rx_data", 32'(b0.rx_data), 32'h A5);
        chk_flags0("a5");
        read_one(0);
        chk("a5_ready_drained", 32'(b0.data_ready), 0);
        chk_flags0("a5_read");

        // Short glitch: false start
        set_line(0, 1'b0);
        repeat (3) @(negedge clk);
        set_line(0, 1'b1);
        repeat (30) @(negedge clk);
        chk("glitch_ready", 32'(b0.data_ready), 0);
        chk_flags0("glitch");

        // Framing error, then recovery with a good frame
        send(0, 8'h3C, 0, 0, 0, 0);
        repeat (CPB) @(negedge clk);
        chk_flags0("frm");
        send(0, 8'h11, 0, 0, 1, 0);
        chk_flags0("frm_recover");
        read_one(0);

        // Even parity instance
        send(1, 8'h07, 1, 1, 1, 0);
        chk("par_ok_ready", 32'(b1.data_ready), 1);
        chk("par_ok_data", 32'(b1.rx_data), 32'h07);
        chk("par_ok_err", 32'(b1.parity_error), 0);
        read_one(1);
        send(1, 8'h07, 1, 0, 1, 0);
        chk("par_bad_err", 32'(b1.parity_error), 32'(pe_exp[1]));
        chk("par_bad_ready", 32'(b1.data_ready), 0);
        chk("par_bad_count", 32'(b1.fifo_count), 0);

        // Overrun: five frames into four slots
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 0, 0, 1, 0);
        chk("ovr_set", 32'(b0.overrun_error), 1);
        chk_flags0("ovr");
        read_one(0);
        chk("ovr_cleared", 32'(b0.overrun_error), 0);
        for (int i = 0; i < 3; i++) read_one(0);
        chk_flags0("ovr_drained");

        // Full FIFO, pop coincident with the push of a fifth frame
        for (int i = 0; i < 4; i++) send(0, 8'(8'h10 + i), 0, 0, 1, 0);
        send(0, 8'h55, 0, 0, 1, 1);
        chk("fullpop_count", 32'(b0.fifo_count), 4);
        chk("fullpop_overrun", 32'(b0.overrun_error), 0);
        chk_flags0("fullpop");
        for (int i = 0; i < 4; i++) read_one(0);

        // Reset in the middle of a data phase with a word held in the FIFO
        send(0, 8'h77, 0, 0, 1, 0);
        chk("prerst_count", 32'(b0.fifo_count), 1);
        drive_bit(0, 1'b0);
        repeat (25) @(negedge clk);
        n_rst = 1'b0;
        #1;
        q0.delete();
        ov_exp = 1'b0; fe_exp[0] = 1'b0; pe_exp[0] = 1'b0;
        chk("midrst_ready", 32'(b0.data_ready), 0);
        chk("midrst_rx_data", 32'(b0.rx_data), 0);
        chk_flags0("midrst");
        set_line(0, 1'b1);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("postrst_ready", 32'(b0.data_ready), 0);
        chk("scoreboard_left", 32'(q0.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised successor to the single-buffer serial receiver, combining start detect, bit timing, shifting and stop check in one FSM.
- Receives asynchronous serial frames: start bit, configurable data width, optional even/odd parity, one stop bit.
- Pushes each good frame into a first-word-fall-through FIFO.
- Reports framing, parity and overrun errors.
- Sits between the serial input pin and the consumer logic that reads received bytes.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first on the line
CLKS_PER_BIT, 10, clk cycles per serial bit (>=4)
PARITY_EN, 0, 1 = parity bit follows data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)
FIFO_DEPTH, 4, receive FIFO entries (power of 2, >=2)

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
serial_in  input  1  asynchronous serial line, idle high
data_read  input  1  pop head of FIFO this cycle (ignored when empty)
rx_data  output  DATA_BITS  FIFO head word, valid while data_ready=1
data_ready  output  1  FIFO not empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries held (0..FIFO_DEPTH)
overrun_error  output  1  sticky: good frame dropped because FIFO full
framing_error  output  1  last frame had stop bit = 0
parity_error  output  1  last frame failed parity check

Behaviour:
Reset values:
- rx_data=0, data_ready=0, fifo_count=0, all error flags 0.
- FSM in IDLE.
- Synchroniser flops reset to 1.
Input synchronisation:
- serial_in passes through a 2-flop synchroniser; "line" below means the synchronised value.
- Start edge = line 1 -> 0, detected only in IDLE.
FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on start edge (cycle t); bit timer cleared.
- START: at t+CLKS_PER_BIT/2 (floor), sample line.
  - 1: false start, return to IDLE, no flag change.
  - 0: clear framing_error and parity_error, go to DATA.
- DATA: sample bit k (k=0..DATA_BITS-1) at t+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT; shift into LSB-first register.
  - After last bit, go to PARITY if PARITY_EN, else STOP.
- PARITY: sample one bit period later.
  - Error if XOR(data,parity bit) != PARITY_ODD.
- STOP: sample one bit period later, then always go to IDLE in the next cycle.
  - A new start edge is accepted from that point, so back-to-back frames work.
Frame disposition at stop sample cycle S:
- Stop=0: framing_error<=1; frame discarded.
- Parity bad: parity_error<=1; frame discarded.
- Both errors can be set together.
- Good frame and FIFO has room: push at S+1; data_ready/rx_data valid at S+1 if FIFO was empty.
- Good frame and FIFO full: frame dropped; overrun_error<=1; FIFO contents unchanged.
FIFO:
- First-word-fall-through; rx_data always shows the oldest entry.
- data_read with data_ready=1 pops at that edge; the next entry is visible the following cycle.
- data_read when empty: no effect, count stays 0.
- Push and pop in the same cycle: count unchanged, data order preserved.
- When full, a simultaneous pop frees the slot: push accepted, no overrun.
- Read and write pointers wrap modulo FIFO_DEPTH.
Error clearing:
- overrun_error clears on the first accepted data_read after it was set.
- framing_error and parity_error hold until the next confirmed start bit.
Reset mid-frame: everything returns to reset values immediately; partial frame lost.

Test Plan:
- Send 0xA5 (8N1, CLKS_PER_BIT=10) -> data_ready rises 1 cycle after stop sample, rx_data=0xA5, fifo_count=1; data_read -> data_ready=0, count=0.
- 0.3-bit low glitch on idle line -> false start; no push, all flags stay 0.
- Send 0x3C with stop bit forced 0 -> framing_error=1, FIFO empty; then a good 0x11 -> framing_error clears at its start confirmation, rx_data=0x11.
- PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity=1 -> accepted. Send 0x07 with parity=0 -> parity_error=1, frame dropped.
- FIFO_DEPTH=4: send 0x01..0x05 back-to-back without reading -> count=4, overrun_error=1; reads return 0x01..0x04, overrun clears on first read.
- FIFO full, data_read asserted in the push cycle of a fifth frame 0x55 -> no overrun, count stays 4, last entry 0x55; assert n_rst mid-DATA -> all outputs back to reset values.
